fmul_issue_queue: RTL and testbench
===================================

Name: fmul_issue_queue

Overview:
Front-end sequencer for the fixed-latency, non-stallable fmul pipeline.
- Accepts tagged operand pairs over a valid/ready handshake and issues them to the multiplier.
- Reserves a result slot for every issued operation, captures results in issue order, and returns {result, ex, tag} over a valid/ready handshake.
- Prevents result loss under downstream backpressure, because the multiplier itself cannot stall.

Parameters:
- FBITS, 32, operand/result width (matches multiplier fbits).
- TAGBITS, 4, request tag width.
- DEPTH, 16, ring entries = max outstanding + buffered ops; power of 2, >=2.
- MUL_LAT, 13, multiplier latency in cycles (i_ena sampled to o_valid; FP32 = 13).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, active-high
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_a  in  FBITS  operand A
- i_req_b  in  FBITS  operand B
- i_req_tag  in  TAGBITS  request tag
- o_mul_ena  out  1  to multiplier i_ena
- o_mul_a  out  FBITS  to multiplier i_a
- o_mul_b  out  FBITS  to multiplier i_b
- i_mul_res  in  FBITS  from multiplier o_res
- i_mul_ex  in  1  from multiplier o_ex
- i_mul_valid  in  1  from multiplier o_valid
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  response consumed when valid&ready
- o_resp_res  out  FBITS  product
- o_resp_ex  out  1  overflow/underflow flag
- o_resp_tag  out  TAGBITS  tag of the originating request
- o_busy  out  1  any entry allocated
- o_err  out  1  sticky: i_mul_valid with no outstanding entry

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high on i_rst. The multiplier reset is driven by the integration as i_nrst = ~i_rst.
- Reset values: all pointers and valid bits 0; o_req_ready=0 during reset and 1 in the first cycle after; o_resp_valid=0, o_busy=0, o_err=0, o_mul_ena=0, data outputs 0.
- Ring storage: DEPTH entries of {tag, res, ex, done}.
- Pointers: three pointers, each $clog2(DEPTH)+1 bits with a wrap bit.
  - alloc_ptr: advances on issue.
  - fill_ptr: advances on i_mul_valid.
  - head_ptr: advances on response pop.
- Occupancy: occ = alloc_ptr - head_ptr (modular). Invariant: head <= fill <= alloc.
- Request handshake:
  - o_req_ready = (occ < DEPTH); a function of registered state only, never of i_req_valid.
  - Issue = i_req_valid & o_req_ready. On issue: o_mul_ena=1 combinationally in the same cycle; o_mul_a/o_mul_b = i_req_a/i_req_b; entry[alloc].tag <= i_req_tag; entry[alloc].done <= 0; alloc++.
  - When not issuing: o_mul_ena=0 and o_mul_a/o_mul_b = 0.
- Completion on i_mul_valid:
  - If fill != alloc: entry[fill].{res,ex,done} <= {i_mul_res, i_mul_ex, 1}; fill++.
  - If fill == alloc: result dropped, o_err <= 1 (cleared only by reset).
- Response:
  - o_resp_valid = (head != fill) & entry[head].done; outputs come directly from entry[head], registered.
  - Pop = o_resp_valid & i_resp_ready; on pop: entry[head].done <= 0; head++.
- Latency: request accepted in cycle T gives the multiplier result in cycle T+MUL_LAT, captured at that edge. o_resp_valid rises in cycle T+MUL_LAT+1 if it is at the head. Sustained throughput is 1 op/cycle while i_resp_ready=1.
- Simultaneous events: issue, completion and pop may occur in the same cycle, and all three apply. occ_next = occ + issue - pop. A pop frees a slot only from the next cycle, with no combinational ready path from i_resp_ready.
- Full: occ==DEPTH drops o_req_ready. In-flight results always have a reserved slot, so no overflow is possible.
- Empty: o_resp_valid=0. o_busy = (occ != 0).
- Wrap-around: pointer MSB distinguishes full from empty; indices are the low bits.
- Reset mid-operation: all entries are discarded and the multiplier pipeline is cleared by the shared reset; no stale response is emitted.
- The ring is not indexed by tags; duplicate tags are legal and returned in order.

Decomposition:
- Shared package fmul_pkg: entry struct typedef (tag, res, ex, done), FP32 constants (MUL_LAT_FP32=13, FP_ONE=32'h3F800000).
- No sub-module; the ring and pointers are inline.
- Top-level integration pairs this block with one multiplier instance.

Test Plan:
- Single op: a=32'h3F800000, b=32'h40000000, tag=5 at T, ready held 1 -> o_mul_ena=1 at T; o_resp_valid at T+14 with res=32'h40000000, ex=0, tag=5, for one cycle.
- Streaming: 32 back-to-back requests, tags 0..15 twice, resp_ready=1 -> o_req_ready never drops; responses in issue order, one per cycle, first at T+14.
- Backpressure/full: resp_ready=0, DEPTH=16, stream requests -> exactly 16 accepted; o_req_ready=0 from the following cycle; no results lost. Raise resp_ready -> 16 ordered responses; ready reasserts the cycle after the first pop.
- Overflow flag: a=b=32'h7F000000 -> res=32'h7FFFFFFF, ex=1, tag preserved.
- Spurious valid: force i_mul_valid=1 with ring empty -> o_err=1 sticky; o_resp_valid stays 0.
- Reset mid-stream: assert i_rst for 1 cycle with 6 ops in flight -> o_busy=0, o_resp_valid=0; no responses emerge over the next 20 cycles; o_req_ready=1 after reset.

Source files
------------

// File: rtl/fmul_pkg.sv
// Types and FP32 constants shared by the fmul front end and its integration.
package fmul_pkg;
  localparam int          MUL_LAT_FP32 = 13;
  localparam int          FP32_BITS    = 32;
  localparam int          TAG_BITS     = 4;
  localparam logic [31:0] FP_ONE       = 32'h3F800000;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [FP32_BITS-1:0] res;
    logic                 ex;
    logic                 done;
  } fmul_entry_t;
endpackage

// File: rtl/fmul_issue_queue.sv
// Issue sequencer for the non-stallable fmul pipeline: reserves a ring slot per
// issued op, captures results in order and returns them over valid/ready.
module fmul_issue_queue
  import fmul_pkg::*;
#(
  parameter int FBITS   = FP32_BITS,
  parameter int TAGBITS = TAG_BITS,
  parameter int DEPTH   = 16,
  parameter int MUL_LAT = MUL_LAT_FP32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [FBITS-1:0]   i_req_a,
  input  logic [FBITS-1:0]   i_req_b,
  input  logic [TAGBITS-1:0] i_req_tag,
  output logic               o_mul_ena,
  output logic [FBITS-1:0]   o_mul_a,
  output logic [FBITS-1:0]   o_mul_b,
  input  logic [FBITS-1:0]   i_mul_res,
  input  logic               i_mul_ex,
  input  logic               i_mul_valid,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [FBITS-1:0]   o_resp_res,
  output logic               o_resp_ex,
  output logic [TAGBITS-1:0] o_resp_tag,
  output logic               o_busy,
  output logic               o_err
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fmul_issue_queue: DEPTH must be a power of 2 and >= 2");
  end
  if (MUL_LAT < 1) begin : g_bad_lat
    $error("fmul_issue_queue: MUL_LAT must be >= 1");
  end

  // Same layout as fmul_entry_t, sized to this instance.
  typedef struct packed {
    logic [TAGBITS-1:0] tag;
    logic [FBITS-1:0]   res;
    logic               ex;
    logic               done;
  } entry_t;

  entry_t        ring [DEPTH];
  logic [AW:0]   alloc_ptr, fill_ptr, head_ptr, occ;
  logic [AW-1:0] alloc_idx, fill_idx, head_idx;
  logic          full, issue, fill_en, pop;

  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign head_idx  = head_ptr[AW-1:0];

  // occ never exceeds DEPTH, so its MSB alone flags a full ring.
  assign occ  = alloc_ptr - head_ptr;
  assign full = occ[AW];

  assign o_req_ready = ~i_rst & ~full;
  assign issue       = i_req_valid & o_req_ready;
  assign o_mul_ena   = issue;
  assign o_mul_a     = issue ? i_req_a : '0;
  assign o_mul_b     = issue ? i_req_b : '0;

  assign fill_en = i_mul_valid & (fill_ptr != alloc_ptr);

  assign o_resp_valid = ~i_rst & (head_ptr != fill_ptr) & ring[head_idx].done;
  assign o_resp_res   = o_resp_valid ? ring[head_idx].res : '0;
  assign o_resp_ex    = o_resp_valid & ring[head_idx].ex;
  assign o_resp_tag   = o_resp_valid ? ring[head_idx].tag : '0;
  assign pop          = o_resp_valid & i_resp_ready;

  assign o_busy = (occ != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      o_err     <= 1'b0;
    end else begin
      if (issue)   alloc_ptr <= alloc_ptr + PTR_ONE;
      if (fill_en) fill_ptr  <= fill_ptr + PTR_ONE;
      if (pop)     head_ptr  <= head_ptr + PTR_ONE;
      if (i_mul_valid && !fill_en) o_err <= 1'b1;
    end
  end

  // Issue, fill and pop never target the same slot in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i].done <= 1'b0;
    end else begin
      if (issue) begin
        ring[alloc_idx].tag  <= i_req_tag;
        ring[alloc_idx].done <= 1'b0;
      end
      if (fill_en) begin
        ring[fill_idx].res  <= i_mul_res;
        ring[fill_idx].ex   <= i_mul_ex;
        ring[fill_idx].done <= 1'b1;
      end
      if (pop) ring[head_idx].done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fmul_issue_queue.sv
// Directed bench for fmul_issue_queue with a fixed-latency multiplier stand-in.
module tb_fmul_issue_queue;
  import fmul_pkg::*;
  localparam int FBITS = 32, TAGBITS = 4, DEPTH = 16, MUL_LAT = 13;

  logic               clk = 1'b0, rst = 1'b1;
  logic               req_valid = 1'b0, req_ready;
  logic [FBITS-1:0]   req_a = '0, req_b = '0;
  logic [TAGBITS-1:0] req_tag = '0;
  logic               mul_ena, mul_ex, mul_valid;
  logic [FBITS-1:0]   mul_a, mul_b, mul_res;
  logic               resp_valid, resp_ready = 1'b1, resp_ex;
  logic [FBITS-1:0]   resp_res;
  logic [TAGBITS-1:0] resp_tag;
  logic               busy, err;
  logic               spur = 1'b0;
  int                 vecs = 0, errs = 0;

  always #5 clk = ~clk;

  fmul_issue_queue #(.FBITS(FBITS), .TAGBITS(TAGBITS), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_tag(req_tag),
    .o_mul_ena(mul_ena), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_res(mul_res), .i_mul_ex(mul_ex), .i_mul_valid(mul_valid),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_res(resp_res), .o_resp_ex(resp_ex), .o_resp_tag(resp_tag),
    .o_busy(busy), .o_err(err)
  );

  // Multiplier stand-in: exact for the directed operands, arbitrary otherwise.
  function automatic logic [32:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == FP_ONE) return {1'b0, b};
    if (b == FP_ONE) return {1'b0, a};
    if (a == 32'h7F000000 && b == 32'h7F000000) return {1'b1, 32'h7FFFFFFF};
    return {1'b0, a ^ b};
  endfunction

  logic [MUL_LAT-1:0] mv;
  logic [32:0]        mpipe [MUL_LAT];
  always @(posedge clk) begin
    if (rst) mv <= '0;
    else     mv <= {mv[MUL_LAT-2:0], mul_ena};
    mpipe[0] <= stub_mul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_valid         = mv[MUL_LAT-1] | spur;
  assign {mul_ex, mul_res} = mpipe[MUL_LAT-1];

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_a = FP_ONE; req_b = FP_ONE; req_tag = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    vecs++; if (mul_ena !== 1'b0) begin errs++; $display("FAIL reset_mul_ena got %b want 0", mul_ena); end
    vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err); end
    vecs++; if (resp_res !== 32'h0) begin errs++; $display("FAIL reset_resp_res got %h want 0", resp_res); end
    req_valid = 1'b0; rst = 1'b0; #1;
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_single_op();
    @(negedge clk);
    req_valid = 1'b1; req_a = FP_ONE; req_b = 32'h40000000; req_tag = 4'd5; #1;
    vecs++; if (mul_ena !== 1'b1) begin errs++; $display("FAIL single_mul_ena got %b want 1", mul_ena); end
    vecs++; if (mul_a !== FP_ONE || mul_b !== 32'h40000000)
      begin errs++; $display("FAIL single_mul_ops got %h/%h want 3f800000/40000000", mul_a, mul_b); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); req_valid = 1'b0; #1;
      if (k == 1) begin
        vecs++; if (mul_ena !== 1'b0 || mul_a !== 32'h0)
          begin errs++; $display("FAIL idle_mul got ena=%b a=%h want 0/0", mul_ena, mul_a); end
      end
      vecs++; if (resp_valid !== (k == 14))
        begin errs++; $display("FAIL single_resp_valid cyc T+%0d got %b want %b", k, resp_valid, k == 14); end
      if (k == 14) begin
        vecs++; if (resp_res !== 32'h40000000) begin errs++; $display("FAIL single_res got %h want 40000000", resp_res); end
        vecs++; if (resp_ex !== 1'b0) begin errs++; $display("FAIL single_ex got %b want 0", resp_ex); end
        vecs++; if (resp_tag !== 4'd5) begin errs++; $display("FAIL single_tag got %0d want 5", resp_tag); end
      end
    end
  endtask

  task automatic test_streaming();
    logic [3:0] et;
    logic       ev;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (k < 32) begin
        req_valid = 1'b1; req_a = FP_ONE; req_b = 32'h40000000 + 32'(k); req_tag = 4'(k);
      end else req_valid = 1'b0;
      #1;
      if (k < 32) begin
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL stream_ready k=%0d got %b want 1", k, req_ready); end
      end
      ev = (k >= 14 && k < 46);
      et = 4'(k - 14);
      vecs++; if (resp_valid !== ev) begin errs++; $display("FAIL stream_valid k=%0d got %b want %b", k, resp_valid, ev); end
      if (ev) begin
        vecs++; if (resp_tag !== et || resp_res !== 32'h40000000 + 32'(k - 14))
          begin errs++; $display("FAIL stream_data k=%0d got tag=%0d res=%h want tag=%0d res=%h",
                                 k, resp_tag, resp_res, et, 32'h40000000 + 32'(k - 14)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    resp_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_a = FP_ONE; req_b = 32'h41000000 + 32'(k); req_tag = 4'(k); #1;
      vecs++; if (req_ready !== (k < 16)) begin errs++; $display("FAIL full_ready k=%0d got %b want %b", k, req_ready, k < 16); end
      if (req_ready === 1'b1) acc++;
    end
    @(negedge clk); req_valid = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    vecs++; if (acc != 16) begin errs++; $display("FAIL full_accepted got %0d want 16", acc); end
    vecs++; if (busy !== 1'b1 || req_ready !== 1'b0)
      begin errs++; $display("FAIL full_state got busy=%b ready=%b want 1/0", busy, req_ready); end
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      resp_ready = 1'b1; #1;
      vecs++; if (resp_valid !== (k < 16)) begin errs++; $display("FAIL drain_valid k=%0d got %b want %b", k, resp_valid, k < 16); end
      if (k < 16) begin
        vecs++; if (resp_tag !== 4'(k) || resp_res !== 32'h41000000 + 32'(k))
          begin errs++; $display("FAIL drain_data k=%0d got tag=%0d res=%h want tag=%0d res=%h",
                                 k, resp_tag, resp_res, k, 32'h41000000 + 32'(k)); end
      end
      vecs++; if (req_ready !== (k != 0)) begin errs++; $display("FAIL drain_ready k=%0d got %b want %b", k, req_ready, k != 0); end
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL drain_busy got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    int lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h7F000000; req_b = 32'h7F000000; req_tag = 4'd9; #1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); req_valid = 1'b0; #1;
      if (resp_valid === 1'b1) begin lat = k; break; end
    end
    vecs++;
    if (lat == 0) begin errs++; $display("FAIL ovf_timeout got no response want one within 30 cycles"); end
    else begin
      if (lat != 14) begin errs++; $display("FAIL ovf_latency got %0d want 14", lat); end
      vecs++; if (resp_res !== 32'h7FFFFFFF || resp_ex !== 1'b1 || resp_tag !== 4'd9)
        begin errs++; $display("FAIL ovf_data got res=%h ex=%b tag=%0d want 7fffffff/1/9", resp_res, resp_ex, resp_tag); end
    end
  endtask

  task automatic test_spurious();
    @(negedge clk); #1;
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL spur_pre_err got %b want 0", err); end
    spur = 1'b1;
    @(negedge clk); spur = 1'b0; #1;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL spur_err got %b want 1", err); end
    vecs++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL spur_state got valid=%b busy=%b want 0/0", resp_valid, busy); end
    repeat (5) @(negedge clk);
    #1;
    vecs++; if (err !== 1'b1 || resp_valid !== 1'b0)
      begin errs++; $display("FAIL spur_sticky got err=%b valid=%b want 1/0", err, resp_valid); end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_a = FP_ONE; req_b = 32'h42000000 + 32'(k); req_tag = 4'(k);
    end
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    rst = 1'b1; #1;
    vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready got %b want 0", req_ready); end
    @(negedge clk); rst = 1'b0; #1;
    vecs++; if (busy !== 1'b0 || resp_valid !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1)
      begin errs++; $display("FAIL mid_post got busy=%b valid=%b err=%b ready=%b want 0/0/0/1",
                             busy, resp_valid, err, req_ready); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (resp_valid !== 1'b0) seen++;
    end
    vecs++; if (seen != 0) begin errs++; $display("FAIL mid_stale got %0d response cycles want 0", seen); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL mid_err got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_spurious();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1);
  end
endmodule
